ad7606_emu: RTL and testbench
=============================

// Module: ad7606_emu
// PURPOSE
// - Parametrised, synthesizable AD7606-style ADC emulator for sim and loopback.
// - Answers the ad7606 controller's convert/read strobes with busy timing and per-channel data.
// - Generalises channel count, data width, conversion time, oversampling and data pattern.
// - Adds protocol-error flagging.
// - Replaces hand-coded busy/data stimulus in the ad7606 benches.
// PARAMETERS
// - CH_NUM       8         channels returned per conversion (1..16)
// - DATA_W       16        sample width
// - CONV_CYCLES  4000      busy length in clk_50 cycles at os=0 (>=2)
// - LFSR_POLY    16'hB400  Galois LFSR feedback mask (DATA_W bits)
// - LFSR_SEED    16'hACE1  LFSR reset value, must be non-zero
// PORTS
// - clk_50      in   1        system clock
// - rst_n       in   1        async active-low reset
// - rst_ad7606  in   1        emulated chip reset, synchronous, active-high
// - cva         in   1        convert start A
// - cvb         in   1        convert start B
// - cs_n        in   1        chip select, active-low
// - rd_n        in   1        read strobe, active-low
// - os          in   3        oversampling ratio code
// - mode        in   2        0 counter, 1 fixed, 2 LFSR, 3 channel-tag
// - seed        in   DATA_W   fixed value used in mode 1
// - busy        out  1        conversion in progress
// - data        out  DATA_W   parallel sample
// - frstdata    out  1        high while data holds channel 0
// - ch_idx      out  4        next channel to be read
// - conv_err    out  1        1-cycle protocol-error pulse
// BEHAVIOUR
// - Reset (rst_n low, or rst_ad7606 high at a posedge):
//   - All outputs 0; state IDLE.
//   - conv_cnt=0; LFSR=LFSR_SEED; edge registers cleared.
// - Edge detection:
//   - cv = cva&cvb, registered once as cv_d; start = cv & ~cv_d.
//   - rd_fall = ~rd_n & rd_n_d & ~cs_n, with rd_n_d reset to 1.
// - FSM IDLE -> CONV -> READ -> IDLE.
// - IDLE:
//   - On start: busy=1 at the next posedge; load conv timer; go CONV.
//   - On rd_fall: data holds; conv_err pulse.
// - CONV:
//   - busy stays high for exactly CONV_CYCLES<<os cycles; os=7 is treated as 0.
//   - start during CONV is ignored; conv_err pulse.
//   - rd_fall during CONV leaves data unchanged; conv_err pulse.
//   - At timer end: busy=0, ch_idx=0, conv_cnt+=1 (wraps at 2^DATA_W); go READ.
// - READ, on each rd_fall, data is registered at the next posedge:
//   - mode0: data = conv_cnt-1 + ch_idx, i.e. the index of the completed conversion plus the channel.
//   - mode1: data = seed.
//   - mode2: data = LFSR, then the LFSR advances one step.
//   - mode3: data = {ch_idx, conv_cnt[DATA_W-5:0]}.
//   - frstdata = (ch_idx==0); ch_idx+=1.
//   - After the CH_NUM-th read: ch_idx=0; go IDLE.
//   - start in READ aborts the remaining reads and enters CONV; this is not an error.
//   - start and rd_fall in the same cycle: start wins; data holds; no conv_err.
// - Width rules: all adds are mod 2^DATA_W; data holds its value between reads.
// CONFIGURATION
// - AD7606_BUSY_JITTER_EN defined:
//   - busy length = (CONV_CYCLES<<os) + LFSR[2:0], sampled at start.
//   - The LFSR advances once per start in every mode.
// - AD7606_BUSY_JITTER_EN undefined:
//   - busy length is exact.
//   - The LFSR advances only on mode-2 reads.
// TESTING (CONV_CYCLES=20, CH_NUM=8, jitter off unless stated)
// - Reset, then cva=cvb=1, os=0 -> busy high exactly 20 cycles, 1 cycle after the edge.
// - mode0, three conversions, 8 reads each -> data 0..7, 1..8, 2..9; frstdata only on first read.
// - mode2, one conversion, 8 reads -> first data 16'hACE1, then successive LFSR steps per golden model.
// - os=2 -> busy 80 cycles. Second start mid-CONV -> conv_err single pulse; busy length unchanged.
// - 3 reads, then new start -> READ aborted, busy=1, ch_idx=0 after conversion. rd_fall in IDLE -> conv_err.
// - rst_ad7606 pulse mid-CONV -> busy=0 next cycle, conv_cnt=0.
// - Jitter on -> busy within 20..27 cycles, matching the LFSR model.

Source files
------------

// File: rtl/ad7606_emu.sv
// ad7606_emu - AD7606-style parallel ADC emulator for simulation and loopback.
//
// Responds to a controller's convert and read strobes the way the real part
// does. A rising edge of (cva & cvb) starts a conversion and raises busy.
// busy falls after the conversion time. Each falling edge of rd_n taken while
// cs_n is low then returns one channel sample on data.
//
// Strobe semantics: a strobe counts only on its edge, never on its level.
// A start is the first cycle with cva&cvb high. A read is the first cycle
// with rd_n low while cs_n is low. data, frstdata and ch_idx change at the
// posedge that sees the read edge, so they are valid one cycle after it.
//
// Parameters:
//   CH_NUM       channels returned per conversion (1..16)
//   DATA_W       sample width (>= 5)
//   CONV_CYCLES  busy length in clk_50 cycles at os=0 (>= 2)
//   LFSR_POLY    Galois LFSR feedback mask
//   LFSR_SEED    LFSR reset value (non-zero)
//
// Ports:
//   clk_50      in   system clock
//   rst_n       in   asynchronous active-low reset
//   rst_ad7606  in   emulated chip reset, synchronous active-high
//   cva, cvb    in   convert start strobes; both must be high to start
//   cs_n, rd_n  in   chip select and read strobe, active-low
//   os          in   oversampling code; busy length is CONV_CYCLES<<os,
//                    and 7 is treated as 0
//   mode        in   data pattern: 0 counter, 1 fixed seed, 2 LFSR, 3 tag
//   seed        in   value returned in mode 1
//   busy        out  conversion in progress
//   data        out  parallel sample, held between reads
//   frstdata    out  high while data holds channel 0
//   ch_idx      out  next channel to be read
//   conv_err    out  one-cycle pulse on a protocol error
//
// Build option: when AD7606_BUSY_JITTER_EN is defined, LFSR[2:0] is added to
// every busy length, and the LFSR advances once per accepted start.

module ad7606_emu #(
  parameter int              CH_NUM      = 8,
  parameter int              DATA_W      = 16,
  parameter int              CONV_CYCLES = 4000,
  parameter logic [DATA_W-1:0] LFSR_POLY = 16'hB400,
  parameter logic [DATA_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk_50,
  input  logic              rst_n,
  input  logic              rst_ad7606,
  input  logic              cva,
  input  logic              cvb,
  input  logic              cs_n,
  input  logic              rd_n,
  input  logic [2:0]        os,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic [DATA_W-1:0] data,
  output logic              frstdata,
  output logic [3:0]        ch_idx,
  output logic              conv_err
);

  // Sized for the largest length: os_eff=6 would be enough, but 7 keeps margin.
  localparam int unsigned MAX_LEN = CONV_CYCLES * 128 + 8;
  localparam int          TW      = $clog2(MAX_LEN + 1);
  localparam logic [3:0]  LAST_CH = 4'(CH_NUM - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    READ = 2'd2
  } state_t;

  state_t            state, state_n;
  logic              busy_n, frstdata_n, conv_err_n;
  logic [DATA_W-1:0] data_n;
  logic [3:0]        ch_idx_n;
  logic [TW-1:0]     timer, timer_n;
  logic [DATA_W-1:0] conv_cnt, conv_cnt_n;
  logic [DATA_W-1:0] lfsr, lfsr_n;
  logic              cv_d, cv_d_n;
  logic              rd_n_d, rd_n_d_n;

  logic              cv, start, rd_fall;
  logic [2:0]        os_eff;
  logic [TW-1:0]     conv_len;
  logic [DATA_W-1:0] lfsr_step;

  assign cv      = cva & cvb;
  assign start   = cv & ~cv_d;
  assign rd_fall = ~rd_n & rd_n_d & ~cs_n;
  assign os_eff  = (os == 3'd7) ? 3'd0 : os;

  // Galois form: shift right and fold the mask in when a 1 drops out.
  assign lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ LFSR_POLY) : (lfsr >> 1);

`ifdef AD7606_BUSY_JITTER_EN
  assign conv_len = (TW'(CONV_CYCLES) << os_eff) + TW'(lfsr[2:0]);
`else
  assign conv_len = TW'(CONV_CYCLES) << os_eff;
`endif

  always_comb begin
    state_n    = state;
    busy_n     = busy;
    data_n     = data;
    frstdata_n = frstdata;
    ch_idx_n   = ch_idx;
    conv_err_n = 1'b0;
    timer_n    = timer;
    conv_cnt_n = conv_cnt;
    lfsr_n     = lfsr;
    cv_d_n     = cv;
    rd_n_d_n   = rd_n;

    if (rst_ad7606) begin
      state_n    = IDLE;
      busy_n     = 1'b0;
      data_n     = '0;
      frstdata_n = 1'b0;
      ch_idx_n   = '0;
      timer_n    = '0;
      conv_cnt_n = '0;
      lfsr_n     = LFSR_SEED;
      cv_d_n     = 1'b0;
      rd_n_d_n   = 1'b1;
    end else begin
      case (state)
        IDLE, READ: begin
          if (start) begin
            // A start in READ abandons the remaining reads. It is legal and
            // outranks a read edge arriving in the same cycle.
            busy_n  = 1'b1;
            timer_n = conv_len - TW'(1);
            state_n = CONV;
`ifdef AD7606_BUSY_JITTER_EN
            lfsr_n  = lfsr_step;
`endif
          end else if (rd_fall) begin
            if (state == IDLE) begin
              conv_err_n = 1'b1;
            end else begin
              case (mode)
                2'd0: data_n = conv_cnt - DATA_W'(1) + DATA_W'(ch_idx);
                2'd1: data_n = seed;
                2'd2: begin
                  data_n = lfsr;
                  lfsr_n = lfsr_step;
                end
                2'd3: data_n = {ch_idx, conv_cnt[DATA_W-5:0]};
              endcase
              frstdata_n = (ch_idx == 4'd0);
              if (ch_idx == LAST_CH) begin
                ch_idx_n = '0;
                state_n  = IDLE;
              end else begin
                ch_idx_n = ch_idx + 4'd1;
              end
            end
          end
        end
        CONV: begin
          if (start || rd_fall) conv_err_n = 1'b1;
          // The timer is loaded with len-1 and busy drops when it reads zero,
          // so busy is high for exactly len cycles.
          if (timer == '0) begin
            busy_n     = 1'b0;
            ch_idx_n   = '0;
            conv_cnt_n = conv_cnt + DATA_W'(1);
            state_n    = READ;
          end else begin
            timer_n = timer - TW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      data     <= '0;
      frstdata <= 1'b0;
      ch_idx   <= '0;
      conv_err <= 1'b0;
      timer    <= '0;
      conv_cnt <= '0;
      lfsr     <= LFSR_SEED;
      cv_d     <= 1'b0;
      rd_n_d   <= 1'b1;
    end else begin
      state    <= state_n;
      busy     <= busy_n;
      data     <= data_n;
      frstdata <= frstdata_n;
      ch_idx   <= ch_idx_n;
      conv_err <= conv_err_n;
      timer    <= timer_n;
      conv_cnt <= conv_cnt_n;
      lfsr     <= lfsr_n;
      cv_d     <= cv_d_n;
      rd_n_d   <= rd_n_d_n;
    end
  end

endmodule

// File: tb/tb_ad7606_emu.sv
// tb_ad7606_emu - self-checking bench for ad7606_emu (CONV_CYCLES=20, CH_NUM=8).
// Inputs change on the falling clock edge. Outputs are sampled on the falling
// edge that follows the rising edge which acted on them.

module tb_ad7606_emu;

  localparam int CC = 20;
  localparam int CH = 8;
  localparam logic [15:0] SEED0 = 16'hACE1;
  localparam logic [15:0] POLY  = 16'hB400;

  logic        clk_50 = 1'b0;
  logic        rst_n, rst_ad7606, cva, cvb, cs_n, rd_n;
  logic [2:0]  os;
  logic [1:0]  mode;
  logic [15:0] seed;
  logic        busy, frstdata, conv_err;
  logic [15:0] data;
  logic [3:0]  ch_idx;

  ad7606_emu #(
    .CH_NUM(CH), .DATA_W(16), .CONV_CYCLES(CC),
    .LFSR_POLY(POLY), .LFSR_SEED(SEED0)
  ) dut (
    .clk_50(clk_50), .rst_n(rst_n), .rst_ad7606(rst_ad7606),
    .cva(cva), .cvb(cvb), .cs_n(cs_n), .rd_n(rd_n),
    .os(os), .mode(mode), .seed(seed),
    .busy(busy), .data(data), .frstdata(frstdata),
    .ch_idx(ch_idx), .conv_err(conv_err)
  );

  // clock/reset block
  always #5 clk_50 = ~clk_50;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // scoreboard and reference model
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] m_cnt;   // completed conversions
  logic [15:0] m_lfsr;
  logic [15:0] m_data;
  int          m_ch;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
  endfunction

  task automatic model_reset();
    m_cnt  = '0;
    m_lfsr = SEED0;
    m_data = '0;
    m_ch   = 0;
    exp_q.delete();
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk_50);
  endtask

  // Start a conversion (optionally with a same-cycle read edge), measure busy,
  // and optionally inject a start and/or read edge at given busy cycles.
  task automatic do_conv(input bit with_rd, input int inj_start, input int inj_rd);
    int exp_len, n, errs, oe;
    oe = (os == 3'd7) ? 0 : int'(os);
    exp_len = CC << oe;
`ifdef AD7606_BUSY_JITTER_EN
    exp_len += int'(m_lfsr[2:0]);
    m_lfsr = lfsr_next(m_lfsr);
`endif
    cva = 1'b1; cvb = 1'b1;
    if (with_rd) begin cs_n = 1'b0; rd_n = 1'b0; end
    tick();
    cva = 1'b0; cvb = 1'b0; rd_n = 1'b1;
    check_eq("busy_rise", busy, 1'b1);
    check_eq("start_no_err", conv_err, 1'b0);
    check_eq("start_data_hold", data, m_data);
    n = 1;
    errs = 0;
    while (busy === 1'b1 && n < exp_len + 50) begin
      if (n == inj_start) begin cva = 1'b1; cvb = 1'b1; end
      if (n == inj_rd) begin cs_n = 1'b0; rd_n = 1'b0; end
      tick();
      cva = 1'b0; cvb = 1'b0; rd_n = 1'b1;
      cs_n = 1'($urandom_range(0, 1));
      if (conv_err === 1'b1) errs++;
      if (busy === 1'b1) n++;
    end
    check_eq("busy_len", n, exp_len);
    check_eq("conv_err_pulses", errs, (inj_start > 0 ? 1 : 0) + (inj_rd > 0 ? 1 : 0));
    check_eq("ch_idx_after_conv", ch_idx, 4'd0);
    check_eq("data_hold_conv", data, m_data);
    m_cnt = m_cnt + 16'd1;
    m_ch  = 0;
  endtask

  task automatic do_read();
    logic [15:0] exp;
    rd_n = 1'b1;
    repeat ($urandom_range(0, 2)) begin
      cs_n = 1'($urandom_range(0, 1));
      tick();
    end
    // a read strobe with chip select high must be ignored
    if ($urandom_range(0, 3) == 0) begin
      cs_n = 1'b1; rd_n = 1'b0;
      tick();
      rd_n = 1'b1;
      tick();
      check_eq("phantom_ch", ch_idx, 4'(m_ch));
    end
    case (mode)
      2'd0: exp = m_cnt - 16'd1 + 16'(m_ch);
      2'd1: exp = seed;
      2'd2: begin exp = m_lfsr; m_lfsr = lfsr_next(m_lfsr); end
      default: exp = {4'(m_ch), m_cnt[11:0]};
    endcase
    exp_q.push_back(exp);
    cs_n = 1'b0; rd_n = 1'b0;
    tick();
    rd_n = 1'b1; cs_n = 1'($urandom_range(0, 1));
    check_eq("rd_data", data, exp_q.pop_front());
    check_eq("rd_frst", frstdata, (m_ch == 0));
    check_eq("rd_no_err", conv_err, 1'b0);
    m_data = exp;
    m_ch = (m_ch + 1) % CH;
    check_eq("rd_ch_idx", ch_idx, 4'(m_ch));
    tick();
  endtask

  task automatic idle_rd();
    cs_n = 1'b0; rd_n = 1'b0;
    tick();
    rd_n = 1'b1; cs_n = 1'b1;
    check_eq("idle_rd_err", conv_err, 1'b1);
    check_eq("idle_rd_hold", data, m_data);
    tick();
    check_eq("idle_err_single", conv_err, 1'b0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; rst_ad7606 = 1'b0;
    cva = 1'b0; cvb = 1'b0; cs_n = 1'b1; rd_n = 1'b1;
    os = 3'd0; mode = 2'd0; seed = 16'h0;
    model_reset();
    repeat (3) tick();
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_data", data, 16'h0);
    check_eq("rst_frst", frstdata, 1'b0);
    check_eq("rst_ch_idx", ch_idx, 4'd0);
    check_eq("rst_err", conv_err, 1'b0);
    rst_n = 1'b1;
    tick();

    // counter pattern, three back-to-back conversions
    for (int c = 0; c < 3; c++) begin
      do_conv(1'b0, -1, -1);
      for (int r = 0; r < CH; r++) do_read();
    end
    idle_rd();

    // LFSR pattern
    mode = 2'd2;
    do_conv(1'b0, -1, -1);
    for (int r = 0; r < CH; r++) do_read();

    // os=2 with an ignored start and a stray read mid-conversion
    os = 3'd2; mode = 2'd3;
    do_conv(1'b0, 30, 50);
    for (int r = 0; r < CH; r++) do_read();

    // abort after three reads with a simultaneous read edge
    os = 3'd7; mode = 2'd1; seed = 16'($urandom);
    do_conv(1'b0, -1, -1);
    for (int r = 0; r < 3; r++) do_read();
    do_conv(1'b1, -1, -1);
    for (int r = 0; r < CH; r++) do_read();
    idle_rd();

    // emulated chip reset mid-conversion
    os = 3'd0; mode = 2'd0;
    cva = 1'b1; cvb = 1'b1;
    tick();
    cva = 1'b0; cvb = 1'b0;
    check_eq("chip_rst_busy_pre", busy, 1'b1);
    repeat (5) tick();
    rst_ad7606 = 1'b1;
    tick();
    rst_ad7606 = 1'b0;
    model_reset();
    check_eq("chip_rst_busy", busy, 1'b0);
    check_eq("chip_rst_data", data, 16'h0);
    check_eq("chip_rst_ch", ch_idx, 4'd0);
    check_eq("chip_rst_frst", frstdata, 1'b0);
    tick();
    do_conv(1'b0, -1, -1);
    for (int r = 0; r < CH; r++) do_read();

    // randomized sessions
    for (int it = 0; it < 8; it++) begin
      k = $urandom_range(0, 4);
      os = (k == 4) ? 3'd7 : 3'(k);
      mode = 2'($urandom_range(0, 3));
      seed = 16'($urandom);
      do_conv(1'($urandom_range(0, 1)), -1, ($urandom_range(0, 1) != 0) ? 10 : -1);
      k = $urandom_range(0, CH);
      for (int r = 0; r < k; r++) do_read();
      if (k == CH && $urandom_range(0, 1) == 1) idle_rd();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
